// File: rtl/lane_request_sequencer.sv
// Lane request front end: sensor sync, per-lane debounce, sticky pending, round-robin one-hot grants.
// Optional emergency override is compiled in when LRS_EMERGENCY_EN is defined.
module lane_request_sequencer #(
  parameter int DEB_TICKS   = 3,
  parameter int GREEN_TICKS = 10,
  parameter int GAP_TICKS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_div,
  input  logic [5:0] sensor,
`ifdef LRS_EMERGENCY_EN
  input  logic       emerg,
  input  logic [2:0] emerg_sel,
`endif
  output logic [5:0] L_out,
  output logic [5:0] pending,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] DEB_MAX   = 4'(DEB_TICKS);
  localparam logic [7:0] GREEN_MAX = 8'(GREEN_TICKS);
  localparam logic [7:0] GAP_MAX   = 8'(GAP_TICKS);

  logic [5:0] sync1_r;
  logic [5:0] sync2_r;
  logic [3:0] deb_cnt_r [6];
  logic [5:0] pending_r;
  logic [5:0] set_s;
  logic [5:0] clr_s;
  logic [2:0] grant_idx_s;
  logic [5:0] grant_mask_s;
  logic       emerg_act_s;
  state_t     state_r;
  logic [5:0] l_out_r;
  logic       busy_r;
  logic [7:0] hold_cnt_r;
  logic [7:0] gap_cnt_r;
  logic [2:0] last_idx_r;
`ifdef LRS_EMERGENCY_EN
  logic       emerg_d_r;
  logic       emerg_ok_s;
`endif

  // Round-robin search: first requesting lane after last, wrapping modulo 6.
  function automatic logic [2:0] pick_next(input logic [5:0] req, input logic [2:0] last);
    logic [2:0] idx;
    logic [2:0] sel;
    sel = 3'd0;
    for (int k = 6; k >= 1; k--) begin
      idx = 3'((int'(last) + k) % 6);
      if (req[idx]) begin
        sel = idx;
      end
    end
    return sel;
  endfunction

  // Two-flop synchroniser for the asynchronous detector inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 6'd0;
      sync2_r <= 6'd0;
    end else begin
      sync1_r <= sensor;
      sync2_r <= sync1_r;
    end
  end

  // Debounce counters: count high ticks, saturate, clear on any low cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        deb_cnt_r[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (!sync2_r[i]) begin
          deb_cnt_r[i] <= 4'd0;
        end else if (clk_div && (deb_cnt_r[i] != DEB_MAX)) begin
          deb_cnt_r[i] <= deb_cnt_r[i] + 4'd1;
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i];
        end
      end
    end
  end

  // Qualification pulse only on the tick that reaches DEB_MAX, so a held input fires once.
  always_comb begin
    set_s = 6'd0;
    for (int i = 0; i < 6; i++) begin
      set_s[i] = sync2_r[i] & clk_div & (deb_cnt_r[i] == (DEB_MAX - 4'd1));
    end
  end

  assign grant_idx_s  = pick_next(pending_r, last_idx_r);
  assign grant_mask_s = 6'b000001 << grant_idx_s;

`ifdef LRS_EMERGENCY_EN
  assign emerg_ok_s  = (emerg_sel <= 3'd5);
  assign emerg_act_s = emerg;
`else
  assign emerg_act_s = 1'b0;
`endif

  // Pending clear source: emergency lane or the lane being granted from IDLE.
  always_comb begin
    clr_s = 6'd0;
`ifdef LRS_EMERGENCY_EN
    if (emerg && emerg_ok_s) begin
      clr_s = 6'b000001 << emerg_sel;
    end else
`endif
    if (!emerg_act_s && (state_r == IDLE) && (|pending_r)) begin
      clr_s = grant_mask_s;
    end else begin
      clr_s = 6'd0;
    end
  end

  // Sticky pending latch; a same-cycle clear beats a set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= 6'd0;
    end else begin
      pending_r <= (pending_r | set_s) & ~clr_s;
    end
  end

  // Grant FSM with hold and gap timers; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      l_out_r    <= 6'd0;
      busy_r     <= 1'b0;
      hold_cnt_r <= 8'd0;
      gap_cnt_r  <= 8'd0;
      last_idx_r <= 3'd5;
`ifdef LRS_EMERGENCY_EN
      emerg_d_r  <= 1'b0;
`endif
    end else begin
`ifdef LRS_EMERGENCY_EN
      emerg_d_r <= emerg;
      if (emerg) begin
        state_r    <= GRANT;
        busy_r     <= 1'b1;
        hold_cnt_r <= GREEN_MAX;
        l_out_r    <= emerg_ok_s ? (6'b000001 << emerg_sel) : 6'd0;
      end else if (emerg_d_r) begin
        l_out_r <= 6'd0;
        if (GAP_TICKS > 0) begin
          state_r   <= GAP;
          gap_cnt_r <= GAP_MAX;
          busy_r    <= 1'b1;
        end else begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      end else
`endif
      begin
        case (state_r)
          IDLE: begin
            if (|pending_r) begin
              state_r    <= GRANT;
              l_out_r    <= grant_mask_s;
              last_idx_r <= grant_idx_s;
              hold_cnt_r <= GREEN_MAX;
              busy_r     <= 1'b1;
            end
          end
          GRANT: begin
            if (clk_div) begin
              hold_cnt_r <= hold_cnt_r - 8'd1;
              if (hold_cnt_r == 8'd1) begin
                l_out_r <= 6'd0;
                if (GAP_TICKS > 0) begin
                  state_r   <= GAP;
                  gap_cnt_r <= GAP_MAX;
                end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                end
              end
            end
          end
          GAP: begin
            if (clk_div) begin
              gap_cnt_r <= gap_cnt_r - 8'd1;
              if (gap_cnt_r == 8'd1) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end
            end
          end
          default: begin
            state_r <= IDLE;
            l_out_r <= 6'd0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign L_out   = l_out_r;
  assign pending = pending_r;
  assign busy    = busy_r;

endmodule
